// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot pixel engine.
// Fixed-point format, FSM states and the escape radius.
package mandel_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_FRAC     = 12;
  localparam int DEF_MAX_ITER = 255;
  localparam int DEF_ITER_W   = 8;

  // Width that holds a squared term without wrapping.
  function automatic int wide_w(input int dw, input int frac);
    return 2 * dw - frac + 1;
  endfunction

  localparam int WIDE_W = 2 * DEF_DW - DEF_FRAC + 1;

  localparam logic signed [WIDE_W-1:0] ESC_LIMIT =
    WIDE_W'(4 << DEF_FRAC);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  typedef logic signed [DEF_DW-1:0] fx_t;

endpackage

// File: rtl/mandel_step.sv
// One combinational z <- z^2 + c step plus the escape test.
// Squares are kept unwrapped so escape is right even for large |c|.
module mandel_step
  import mandel_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int FRAC = DEF_FRAC
) (
  input  logic signed [DW-1:0] zr,
  input  logic signed [DW-1:0] zi,
  input  logic signed [DW-1:0] cr,
  input  logic signed [DW-1:0] ci,
  output logic signed [DW-1:0] next_zr,
  output logic signed [DW-1:0] next_zi,
  output logic                 escape
);

  localparam int W = wide_w(DW, FRAC);

  localparam logic signed [W-1:0] LIM =
    W'(4 << FRAC);

  logic signed [2*DW-1:0] pr;
  logic signed [2*DW-1:0] pi;
  logic signed [2*DW-1:0] px;
  logic signed [W-1:0]    sr;
  logic signed [W-1:0]    si;
  logic signed [W-1:0]    x;
  logic signed [W-1:0]    mag;
  logic signed [W-1:0]    nr;
  logic signed [W-1:0]    ni;

  always_comb begin
    pr  = zr * zr;
    pi  = zi * zi;
    px  = zr * zi;
    sr  = W'(pr >>> FRAC);
    si  = W'(pi >>> FRAC);
    // Shift one less to fold the factor of two in 2*zr*zi.
    x   = W'(px >>> (FRAC - 1));
    mag = sr + si;
    escape = mag > LIM;
    nr  = sr - si + W'(cr);
    ni  = x + W'(ci);
    next_zr = nr[DW-1:0];
    next_zi = ni[DW-1:0];
  end

endmodule

// File: rtl/mandel_pixel_engine.sv
// Escape-time engine for one pixel: accept c, iterate, hand back
// the count; pixel_done steps the downstream address counter.
module mandel_pixel_engine
  import mandel_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int FRAC     = DEF_FRAC,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int ITER_W   = DEF_ITER_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] c_re,
  input  logic signed [DW-1:0] c_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ITER_W-1:0]    iter,
  output logic                 in_set,
  output logic                 pixel_done
);

  localparam logic [ITER_W-1:0] CAP = ITER_W'(MAX_ITER);

  state_t state;
  state_t state_n;

  logic signed [DW-1:0] zr;
  logic signed [DW-1:0] zi;
  logic signed [DW-1:0] cr_q;
  logic signed [DW-1:0] ci_q;
  logic signed [DW-1:0] next_zr;
  logic signed [DW-1:0] next_zi;
  logic                 escape;
  logic [ITER_W-1:0]    count;

  mandel_step #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_step (
    .zr      (zr),
    .zi      (zi),
    .cr      (cr_q),
    .ci      (ci_q),
    .next_zr (next_zr),
    .next_zi (next_zi),
    .escape  (escape)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    pixel_done = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ITER;
      end
      ITER: begin
        if (escape || count == CAP)
          state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pixel_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zr     <= '0;
      zi     <= '0;
      cr_q   <= '0;
      ci_q   <= '0;
      count  <= '0;
      iter   <= '0;
      in_set <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cr_q  <= c_re;
            ci_q  <= c_im;
            zr    <= '0;
            zi    <= '0;
            count <= '0;
          end
        end
        ITER: begin
          if (escape) begin
            iter   <= count;
            in_set <= 1'b0;
          end else if (count == CAP) begin
            iter   <= CAP;
            in_set <= 1'b1;
          end else begin
            zr    <= next_zr;
            zi    <= next_zi;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
